tx_word_fifo: RTL
=================

TX_WORD_FIFO -- requirements
Module: tx_word_fifo

Interface
REQ-001 Parameter DATA_W, 32, width of each input word in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH_LOG2, 5, log2 of FIFO depth in words (DEPTH = 2**DEPTH_LOG2).
REQ-003 Parameter MSB_FIRST, 1, byte order: 1 sends bits [DATA_W-1:DATA_W-8] first, 0 sends bits [7:0] first.
REQ-004 CLK  in  1  the block's single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 data  in  DATA_W  word to enqueue.
REQ-007 start  in  1  enqueue strobe for data, one word per cycle.
REQ-008 full  out  1  FIFO holds DEPTH words; start is not accepted.
REQ-009 overflow  out  1  sticky flag: a start arrived while full.
REQ-010 sender_ready  in  1  downstream UART sender accepts output_data this cycle.
REQ-011 output_data  out  8  byte presented to the sender.
REQ-012 valid  out  1  output_data holds a byte to transfer.
REQ-013 byte_last  out  1  output_data is the final byte of its word.
REQ-014 level  out  DEPTH_LOG2+1  word occupancy; present only under TX_WORD_FIFO_LEVEL_EN.

Function
REQ-015 NBYTES = DATA_W/8; storage SHALL be DEPTH words; head/tail pointers DEPTH_LOG2 bits wide, wrapping modulo DEPTH; count DEPTH_LOG2+1 bits.
REQ-016 full SHALL be combinational (count == DEPTH); start && !full SHALL write data at tail, advance tail, and increment count at the same edge.
REQ-017 start && full SHALL discard data, leave pointers unchanged, and set overflow; overflow clears only on reset.
REQ-018 A push and a final-byte pop in the same cycle SHALL leave count unchanged; admission uses the pre-edge count, so a push while full SHALL be dropped even if a pop occurs that cycle.
REQ-019 Read FSM states: IDLE, SEND; byte index idx ranges 0..NBYTES-1.
REQ-020 IDLE: if count != 0, load byte 0 of word[head] into output_data, set valid = 1, set idx = 0, go to SEND; first byte is visible one cycle after the push edge, with no dependence on sender_ready.
REQ-021 SEND: a byte transfers on an edge where valid && sender_ready; without sender_ready, output_data, byte_last and idx SHALL hold.
REQ-022 SEND, transfer with idx < NBYTES-1: present byte idx+1 and increment idx.
REQ-023 SEND, transfer with idx == NBYTES-1: pop head (advance head, decrement count); if another word remains, present its byte 0 with valid held high (no bubble); otherwise clear valid and go to IDLE.
REQ-024 byte_last SHALL be high exactly while idx == NBYTES-1 and valid == 1.
REQ-025 A word in transmission SHALL keep its slot, and count toward full, until its last byte transfers.

Reset
REQ-026 On reset: output_data = 0, valid = 0, byte_last = 0, overflow = 0, head = tail = 0, count = 0, FSM = IDLE, idx = 0; reset SHALL take priority over start and sender_ready.
REQ-027 Reset during a word SHALL abandon that word; no further bytes of it are emitted and the storage contents need not be cleared.

Configuration
REQ-028 Macro TX_WORD_FIFO_LEVEL_EN defined: port level SHALL exist and equal count (registered, updated at the same edge as count).
REQ-029 Macro TX_WORD_FIFO_LEVEL_EN undefined: port level SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package tx_buf_pkg SHALL hold the byte-width constant (8) and the read-FSM state enum typedef.
REQ-031 Storage and pointer/count logic SHALL live in sub-module tx_word_fifo_mem; the serialiser FSM SHALL live in tx_word_fifo.

Verification (DATA_W=32, DEPTH_LOG2=2 unless stated)
REQ-032 Push 0xA1B2C3D4 with sender_ready=1 -> output_data A1,B2,C3,D4 on consecutive transfers; byte_last only with D4; valid=0 the cycle after the D4 transfer.
REQ-033 MSB_FIRST=0, push 0xA1B2C3D4 -> D4,C3,B2,A1 in that order.
REQ-034 sender_ready=0, push 5 words 1..5 -> full=1 after the 4th push; word 5 dropped; overflow=1; enabling sender_ready drains exactly words 1..4 in order.
REQ-035 Push 0x11223344 and 0x55667788 back-to-back, sender_ready=1 -> 8 transfers with valid continuously high, no gap.
REQ-036 sender_ready toggling 1,0,0,1 mid-word -> output_data stable while low; no byte skipped or duplicated.
REQ-037 Assert reset after the 2nd byte -> valid=0, full=0, overflow=0, and level=0 (LEVEL_EN build) on the next cycle; a new push sends its byte 0 first.

Source files
------------

// File: rtl/tx_buf_pkg.sv
// Shared constants and read-FSM state type for the word-to-byte transmit FIFO.
// Used by tx_word_fifo (optional level port enabled by TX_WORD_FIFO_LEVEL_EN).
package tx_buf_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rd_state_e;
endpackage

// File: rtl/tx_word_fifo_if.sv
// Producer/sender bundle for tx_word_fifo; level exists only when
// TX_WORD_FIFO_LEVEL_EN is defined.
interface tx_word_fifo_if
  import tx_buf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5
);
  logic [DATA_W-1:0] data;
  logic              start;
  logic              full;
  logic              overflow;
  logic              sender_ready;
  logic [BYTE_W-1:0] output_data;
  logic              valid;
  logic              byte_last;
`ifdef TX_WORD_FIFO_LEVEL_EN
  logic [DEPTH_LOG2:0] level;

  modport master (
    output data, start, sender_ready,
    input  full, overflow, output_data, valid, byte_last, level
  );
  modport slave (
    input  data, start, sender_ready,
    output full, overflow, output_data, valid, byte_last, level
  );
`else
  modport master (
    output data, start, sender_ready,
    input  full, overflow, output_data, valid, byte_last
  );
  modport slave (
    input  data, start, sender_ready,
    output full, overflow, output_data, valid, byte_last
  );
`endif
endinterface

// File: rtl/tx_word_fifo_mem.sv
// Word storage with head/tail pointers, occupancy count and sticky overflow.
// Also exposes the word after head so the serialiser can chain words without a bubble.
module tx_word_fifo_mem #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_push,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic [DATA_W-1:0]     o_head_word,
  output logic [DATA_W-1:0]     o_next_word,
  output logic                  o_next_avail,
  output logic [DEPTH_LOG2:0]   o_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_many;
  logic [DEPTH_LOG2-1:0] w_head_nxt;

  assign w_full     = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_push_ok  = i_push && !w_full;
  assign w_many     = (r_count > (DEPTH_LOG2+1)'(1));
  assign w_head_nxt = r_head + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push_ok) begin
      r_mem[r_tail] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (i_pop)     r_head <= w_head_nxt;
      case ({w_push_ok, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && w_full) r_overflow <= 1'b1;
    end
  end

  // With a single word stored, the follow-on word can only be the one arriving this cycle.
  assign o_next_word  = w_many ? r_mem[w_head_nxt] : i_wr_data;
  assign o_next_avail = w_many || w_push_ok;

  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_head_word = r_mem[r_head];
  assign o_count     = r_count;
endmodule

// File: rtl/tx_word_fifo.sv
// Word FIFO feeding a byte-wide UART sender; serialises each word MSB- or LSB-first.
// Optional occupancy port level is built when TX_WORD_FIFO_LEVEL_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | nothing presented; load byte 0 of the head word once count != 0
// ST_SEND | output_data holds byte idx of the head word, waiting for sender_ready
module tx_word_fifo
  import tx_buf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic          CLK,
  input  logic          reset,
  tx_word_fifo_if.slave bus
);
  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  function automatic logic [BYTE_W-1:0] f_byte(input logic [DATA_W-1:0] word,
                                                input logic [IDX_W-1:0]  idx);
    int sel;
    sel = MSB_FIRST ? (NBYTES - 1 - int'(idx)) : int'(idx);
    return word[sel*BYTE_W +: BYTE_W];
  endfunction

  rd_state_e           r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [BYTE_W-1:0]   r_output_data;
  logic                r_valid;
  logic                r_byte_last;

  logic [DATA_W-1:0]   w_head_word;
  logic [DATA_W-1:0]   w_next_word;
  logic                w_next_avail;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_overflow;
  logic                w_last_idx;
  logic                w_pop;
  logic [IDX_W-1:0]    w_idx_inc;

  assign w_last_idx = (r_idx == IDX_W'(NBYTES - 1));
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_pop      = (r_state == ST_SEND) && r_valid && bus.sender_ready && w_last_idx;

  tx_word_fifo_mem #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .i_clk        (CLK),
    .i_reset      (reset),
    .i_wr_data    (bus.data),
    .i_push       (bus.start),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_overflow   (w_overflow),
    .o_head_word  (w_head_word),
    .o_next_word  (w_next_word),
    .o_next_avail (w_next_avail),
    .o_count      (w_count)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_output_data <= '0;
      r_valid       <= 1'b0;
      r_byte_last   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_count != '0) begin
            r_output_data <= f_byte(w_head_word, '0);
            r_idx         <= '0;
            r_valid       <= 1'b1;
            r_byte_last   <= (NBYTES == 1);
            r_state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.sender_ready) begin
            if (!w_last_idx) begin
              r_output_data <= f_byte(w_head_word, w_idx_inc);
              r_idx         <= w_idx_inc;
              r_byte_last   <= (w_idx_inc == IDX_W'(NBYTES - 1));
            end else if (w_next_avail) begin
              // Chain straight into the next word so valid never drops between words.
              r_output_data <= f_byte(w_next_word, '0);
              r_idx         <= '0;
              r_byte_last   <= (NBYTES == 1);
            end else begin
              r_idx       <= '0;
              r_valid     <= 1'b0;
              r_byte_last <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.output_data = r_output_data;
  assign bus.valid       = r_valid;
  assign bus.byte_last   = r_byte_last;
  assign bus.full        = w_full;
  assign bus.overflow    = w_overflow;
`ifdef TX_WORD_FIFO_LEVEL_EN
  assign bus.level       = w_count;
`endif
endmodule
